// File: rtl/bcd_run_sequencer.sv
// bcd_run_sequencer
// Run/hold/direction sequencer for a two-digit BCD tally (00..99). The tally
// steps once every TICK_DIV clocks while running, and the two digits share a
// single active-low 7-segment decoder through a free-running scan scheduler.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   level; a rising edge starts or resumes counting
//   stop   in   level; a rising edge holds the count while running
//   clr    in   level; while high, clears the tally and returns to IDLE
//   up     in   direction: 1 = count up, 0 = count down
//   state  out  FSM state: IDLE=00, RUN_UP=01, RUN_DOWN=10, HOLD=11
//   ones   out  BCD ones digit
//   tens   out  BCD tens digit
//   tick   out  one-clock step strobe, high only while running
//   seg    out  active-low segments of the digit currently selected
//   an     out  active-low digit enables; an[0] = ones, an[1] = tens
//
// Command priority, highest first: clr, stop rising edge, start rising edge,
// direction change. A step due on the same edge as clr or a stop edge is
// dropped so the command wins.
module bcd_run_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       up,
  output logic [1:0] state,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tick,
  output logic [6:0] seg,
  output logic [1:0] an
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_UP   = 2'b01,
    RUN_DOWN = 2'b10,
    HOLD     = 2'b11
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  state_t        state_q, state_d;
  logic          start_q, stop_q;
  logic          start_rise, stop_rise;
  logic          running, running_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ones_q, ones_d, tens_q, tens_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          sel_q, sel_d;
  logic [3:0]    digit;

  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;
  assign running    = (state_q == RUN_UP) || (state_q == RUN_DOWN);
  assign running_d  = (state_d == RUN_UP) || (state_d == RUN_DOWN);
  assign tick       = running && (presc_q == PRESC_LAST);

  // Next state. A start edge while running and a stop edge while idle or
  // held are ignored; the direction input is followed on every running edge.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, HOLD: if (start_rise) state_d = up ? RUN_UP : RUN_DOWN;
        RUN_UP: begin
          if (stop_rise)  state_d = HOLD;
          else if (!up)   state_d = RUN_DOWN;
        end
        RUN_DOWN: begin
          if (stop_rise)  state_d = HOLD;
          else if (up)    state_d = RUN_UP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The prescaler only advances across edges where the block stays running,
  // so every entry into a running state starts from zero.
  always_comb begin
    presc_d = '0;
    if (running && running_d) presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Tally step. Direction comes from the registered state, so a direction
  // change landing on a tick edge only affects later ticks.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (tick && !stop_rise) begin
      if (state_q == RUN_UP) begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  // Scan scheduler: sel flips after SCAN_DIV clocks on each digit.
  always_comb begin
    scan_d = scan_q + 1'b1;
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      presc_q <= '0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      scan_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      stop_q  <= stop;
      presc_q <= presc_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
    end
  end

  assign state = state_q;
  assign ones  = ones_q;
  assign tens  = tens_q;
  assign an    = sel_q ? 2'b01 : 2'b10;
  assign digit = sel_q ? tens_q : ones_q;

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_bcd_run_sequencer.sv
// Bench for bcd_run_sequencer: directed scenarios with literal expectations,
// followed by random commands, all compared every cycle against a behavioural
// model that keeps the tally as a single integer 0..99.
module tb_bcd_run_sequencer;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clr = 1'b0, up = 1'b0;
  logic [1:0] state;
  logic [3:0] ones, tens;
  logic       tick;
  logic [6:0] seg;
  logic [1:0] an;

  always #5 clk = ~clk;

  bcd_run_sequencer #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .up(up),
    .state(state), .ones(ones), .tens(tens), .tick(tick), .seg(seg), .an(an)
  );

  int vectors = 0;
  int miscompares = 0;
  int tick_seen = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_state uses the output codes: 0 idle, 1 up, 2 down, 3 hold.
  int m_state, m_count, m_phase, m_cycles;
  bit m_start_q, m_stop_q;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [10];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tab[d];
  endfunction

  function automatic bit m_running();
    return (m_state == 1) || (m_state == 2);
  endfunction

  function automatic bit m_tick();
    return m_running() && (m_phase == TICK_DIV - 1);
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_phase = 0; m_cycles = 0;
    m_start_q = 0; m_stop_q = 0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit c, input bit u);
    bit sr, pr, run, tk;
    int ns;
    sr  = s && !m_start_q;
    pr  = p && !m_stop_q;
    run = m_running();
    tk  = m_tick();
    ns  = m_state;
    if (c)              ns = 0;
    else if (run && pr) ns = 3;
    else if (!run && sr) ns = u ? 1 : 2;
    else if (run)       ns = u ? 1 : 2;
    if (c) m_count = 0;
    else if (tk && !pr) m_count = (m_state == 1) ? (m_count + 1) % 100 : (m_count + 99) % 100;
    if (run && (ns == 1 || ns == 2)) m_phase = (m_phase + 1) % TICK_DIV;
    else m_phase = 0;
    m_state   = ns;
    m_start_q = s;
    m_stop_q  = p;
    m_cycles++;
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      int sel;
      @(negedge clk);
      sel = (m_cycles / SCAN_DIV) % 2;
      chk("state", 32'(state), 32'(m_state));
      chk("ones",  32'(ones),  32'(m_count % 10));
      chk("tens",  32'(tens),  32'(m_count / 10));
      chk("tick",  32'(tick),  32'(m_tick()));
      chk("an",    32'(an),    sel ? 32'h1 : 32'h2);
      chk("seg",   32'(seg),   32'(seg_of(sel ? m_count / 10 : m_count % 10)));
      if (tick) tick_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after a rising edge; the model advances on the edge.
  task automatic cyc(input bit s, input bit p, input bit c, input bit u);
    start = s; stop = p; clr = c; up = u;
    @(posedge clk);
    if (!rst) model_edge(s, p, c, u);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic run_up_to(input int n);
    do_reset();
    cyc(1, 0, 0, 1);
    repeat (n * TICK_DIV) cyc(0, 0, 0, 1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int t0;
    logic [1:0] prev_an;
    int an_changes;
    model_reset();
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_ones",  32'(ones), 0);
    chk("rst_an",    32'(an), 32'h2);
    chk("rst_seg",   32'(seg), 32'b1000000);
    chk("rst_tick",  32'(tick), 0);
    repeat (2) cyc(0, 0, 0, 0);
    rst = 1'b0;

    // Count up: 40 clocks after a start pulse gives 10 ticks and 10.
    cyc(1, 0, 0, 1);
    t0 = tick_seen;
    repeat (40) cyc(0, 0, 0, 1);
    chk("up_state", 32'(state), 1);
    chk("up_ticks", 32'(tick_seen - t0), 10);
    chk("up_tens",  32'(tens), 1);
    chk("up_ones",  32'(ones), 0);

    // Down-count wrap, then reverse across the wrap.
    do_reset();
    cyc(1, 0, 0, 0);
    chk("dn_state", 32'(state), 2);
    repeat (TICK_DIV) cyc(0, 0, 0, 0);
    chk("dn_99", 32'({tens, ones}), 32'h99);
    repeat (TICK_DIV) cyc(0, 0, 0, 0);
    chk("dn_98", 32'({tens, ones}), 32'h98);
    repeat (TICK_DIV) cyc(0, 0, 0, 1);
    chk("rev_99", 32'({tens, ones}), 32'h99);
    chk("rev_state", 32'(state), 1);
    repeat (TICK_DIV) cyc(0, 0, 0, 1);
    chk("rev_00", 32'({tens, ones}), 32'h00);

    // Hold and resume.
    run_up_to(7);
    cyc(0, 1, 0, 1);
    chk("hold_state", 32'(state), 3);
    t0 = tick_seen;
    repeat (20) cyc(0, 0, 0, 1);
    chk("hold_digits", 32'({tens, ones}), 32'h07);
    chk("hold_ticks",  32'(tick_seen - t0), 0);
    cyc(1, 0, 0, 1);
    chk("resume_state", 32'(state), 1);
    repeat (TICK_DIV - 1) cyc(0, 0, 0, 1);
    chk("resume_early", 32'({tens, ones}), 32'h07);
    cyc(0, 0, 0, 1);
    chk("resume_08", 32'({tens, ones}), 32'h08);

    // Priority: clr beats stop, clr beats start, held start counts once.
    run_up_to(7);
    cyc(0, 1, 1, 1);
    chk("clr_stop_state",  32'(state), 0);
    chk("clr_stop_digits", 32'({tens, ones}), 32'h00);
    cyc(1, 0, 1, 1);
    chk("clr_start_state", 32'(state), 0);
    cyc(0, 0, 0, 1);
    repeat (10) cyc(1, 0, 0, 1);
    chk("held_start_run", 32'(state), 1);
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    chk("held_start_once", 32'(state), 3);

    // Asynchronous reset between edges at 42.
    run_up_to(42);
    chk("pre_rst_42", 32'({tens, ones}), 32'h42);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_state",  32'(state), 0);
    chk("arst_digits", 32'({tens, ones}), 32'h00);
    chk("arst_an",     32'(an), 32'h2);
    chk("arst_seg",    32'(seg), 32'b1000000);
    repeat (2) cyc(0, 0, 0, 1);
    rst = 1'b0;
    repeat (10) cyc(0, 0, 0, 1);
    chk("post_rst_idle", 32'({tens, ones}), 32'h00);

    // Scan at 35, held.
    run_up_to(35);
    cyc(0, 1, 0, 1);
    chk("scan_35", 32'({tens, ones}), 32'h35);
    prev_an = an;
    an_changes = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1);
      #2;
      if (an != prev_an) an_changes++;
      prev_an = an;
      if (an == 2'b10) chk("scan_seg_ones", 32'(seg), 32'b0010010);
      else             chk("scan_seg_tens", 32'({an, seg}), 32'({2'b01, 7'b0110000}));
    end
    chk("scan_toggles", 32'(an_changes), 8 / SCAN_DIV);

    // Random commands, checked every cycle by the compare process.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit s, p, c, u;
      s = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 59) == 0);
      u = ($urandom_range(0, 19) == 0) ? ~up : up;
      cyc(s, p, c, u);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
